// File: rtl/mul_final_adder.sv
// Two-stage split carry-propagate adder resolving the multiplier tree's carry-save output into a 32-bit product word.
// Optional MUL_FULL_PRODUCT_EN adds out_prod carrying the full registered 64-bit product.
module mul_final_adder #(
   parameter int SPLIT = 33,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [65:0]     in_a,
   input  logic [65:0]     in_b,
   input  logic            in_cin,
   input  logic            in_high,
   output logic            out_valid,
   input  logic            out_ready,
`ifdef MUL_FULL_PRODUCT_EN
   output logic [2*XLEN-1:0] out_prod,
`endif
   output logic [XLEN-1:0] out_result
);

   localparam int HW = 66 - SPLIT;

   logic             s1_valid;
   logic             s2_valid;
   logic [SPLIT-1:0] lo_sum;
   logic             lo_c;
   logic [HW-1:0]    a_hi;
   logic [HW-1:0]    b_hi;
   logic             high;

   logic             s2_adv;
   logic             accept;
   logic [SPLIT:0]   lo_full;
   logic [HW-1:0]    hi_sum;
   logic [65:0]      p;
   logic [XLEN-1:0]  word;
   logic             unused_p_top;

   assign s2_adv   = s1_valid & (~s2_valid | out_ready);
   assign in_ready = resetn & (~s1_valid | s2_adv);
   assign accept   = in_valid & in_ready;

   assign lo_full = {1'b0, in_a[SPLIT-1:0]} + {1'b0, in_b[SPLIT-1:0]} + {{SPLIT{1'b0}}, in_cin};
   assign hi_sum  = a_hi + b_hi + {{(HW-1){1'b0}}, lo_c};
   assign p       = {hi_sum, lo_sum};
   assign word    = high ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
   // Bits above the 64-bit product are carry overflow and intentionally dropped.
   assign unused_p_top = ^p[65:2*XLEN];

   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         lo_sum     <= '0;
         lo_c       <= 1'b0;
         a_hi       <= '0;
         b_hi       <= '0;
         high       <= 1'b0;
         out_result <= '0;
`ifdef MUL_FULL_PRODUCT_EN
         out_prod   <= '0;
`endif
      end else begin
         if (flush)
            s1_valid <= 1'b0;
         else if (accept)
            s1_valid <= 1'b1;
         else if (s2_adv)
            s1_valid <= 1'b0;

         if (flush)
            s2_valid <= 1'b0;
         else if (s2_adv)
            s2_valid <= 1'b1;
         else if (out_ready)
            s2_valid <= 1'b0;

         if (accept) begin
            lo_sum <= lo_full[SPLIT-1:0];
            lo_c   <= lo_full[SPLIT];
            a_hi   <= in_a[65:SPLIT];
            b_hi   <= in_b[65:SPLIT];
            high   <= in_high;
         end

         if (s2_adv) begin
            out_result <= word;
`ifdef MUL_FULL_PRODUCT_EN
            out_prod   <= p[2*XLEN-1:0];
`endif
         end
      end
   end

endmodule
